hazard_scoreboard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the decode stage. It tracks in-flight writebacks in EX and MEM

---
 rtl/hazard_scoreboard_ctrl_pkg.sv | 24 ++
 rtl/hazard_scoreboard_ctrl_match.sv | 22 ++
 rtl/hazard_scoreboard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared slot layout, decision encoding and defaults for the decode-stage hazard controller.
package hazard_scoreboard_ctrl_pkg;

  localparam int HZ_REG_ADDR_W = 4;
  localparam int HZ_MAX_WAIT   = 64;

  // Slot bit layout: {dest, mem_read, wb_en, v}
  localparam int SB_V    = 0;
  localparam int SB_WB   = 1;
  localparam int SB_MR   = 2;
  localparam int SB_DEST = 3;

  typedef enum logic [1:0] {
    DEC_ISSUE  = 2'd0,
    DEC_STALL  = 2'd1,
    DEC_FLUSH  = 2'd2,
    DEC_FREEZE = 2'd3
  } decision_t;

  function automatic int sb_slot_len(input int addr_w);
    return SB_DEST + addr_w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_ctrl_match.sv
// RAW match of one scoreboard slot against the ID sources; load_only restricts it to load producers.
module sb_slot_match
  import hazard_scoreboard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W
) (
  input  logic [sb_slot_len(REG_ADDR_W)-1:0] slot,
  input  logic [REG_ADDR_W-1:0]              src1,
  input  logic [REG_ADDR_W-1:0]              src2,
  input  logic                               two_src,
  input  logic                               load_only,
  output logic                               match
);

  logic [REG_ADDR_W-1:0] dest;
  logic                  hit;

  assign dest  = slot[SB_DEST +: REG_ADDR_W];
  assign hit   = (dest == src1) | (two_src & (dest == src2));
  assign match = slot[SB_V] & slot[SB_WB] & hit & (~load_only | slot[SB_MR]);

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage sequencer: 2-slot writeback scoreboard (EX, MEM), stall/flush/freeze decode,
// saturating stall-cycle counter and sticky memory-wait timeout.
module hazard_scoreboard_ctrl
  import hazard_scoreboard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W,
  parameter int CNT_W      = 16,
  parameter int MAX_WAIT   = HZ_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  fwd_en,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  hazard,
  output logic                  freeze_if,
  output logic                  bubble_ex,
  output logic                  flush,
  output logic                  freeze_all,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  mem_timeout
);

  localparam int SLOT_LEN = sb_slot_len(REG_ADDR_W);
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  // Index 0 is the EX slot, index 1 the MEM slot.
  logic [SLOT_LEN-1:0] slot_reg [2];
  logic [1:0]          match;
  logic                raw;
  decision_t           dec;
  logic [SLOT_LEN-1:0] ex_next;
  logic [CNT_W-1:0]    stall_reg;
  logic [WAIT_W-1:0]   wait_reg;
  logic                timeout_reg;

  // With forwarding only a load in EX is unresolvable; MEM results are bypassed.
  for (genvar gi = 0; gi < 2; gi++) begin : g_match
    sb_slot_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
      .slot      (slot_reg[gi]),
      .src1      (id_src1),
      .src2      (id_src2),
      .two_src   (id_two_src),
      .load_only ((gi == 0) ? fwd_en : 1'b0),
      .match     (match[gi])
    );
  end

  assign raw = match[0] | (match[1] & ~fwd_en);

  always_comb begin
    dec = DEC_ISSUE;
    if (mem_busy)                dec = DEC_FREEZE;
    else if (branch_taken)       dec = DEC_FLUSH;
    else if (id_valid && raw)    dec = DEC_STALL;
  end

  assign freeze_all = (dec == DEC_FREEZE);
  assign flush      = (dec == DEC_FLUSH);
  assign hazard     = (dec == DEC_STALL);
  assign bubble_ex  = hazard;
  assign freeze_if  = hazard | freeze_all;

  assign ex_next = (dec == DEC_ISSUE) ? {id_dest, id_mem_read, id_wb_en, id_valid} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg[0] <= '0;
      slot_reg[1] <= '0;
      stall_reg   <= '0;
      wait_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (dec != DEC_FREEZE) begin
        slot_reg[0] <= ex_next;
        slot_reg[1] <= slot_reg[0];
      end
      if ((hazard || freeze_all) && (stall_reg != '1))
        stall_reg <= stall_reg + 1'b1;
      if (!mem_busy)
        wait_reg <= '0;
      else if (wait_reg != WAIT_SAT)
        wait_reg <= wait_reg + 1'b1;
      if (mem_busy && (wait_reg == WAIT_LAST))
        timeout_reg <= 1'b1;
    end
  end

  assign stall_cycles = stall_reg;
  assign mem_timeout  = timeout_reg;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed scenarios plus random traffic, checked against a queue-based in-flight model.
module tb_hazard_scoreboard_ctrl;

  localparam int AW       = 4;
  localparam int CW       = 4;
  localparam int MAXW     = 4;
  localparam int CNT_SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_two_src, id_wb_en, id_mem_read, fwd_en, branch_taken, mem_busy;
  logic [AW-1:0] id_src1, id_src2, id_dest;
  logic          hazard, freeze_if, bubble_ex, flush, freeze_all, mem_timeout;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          v;
    bit          wb;
    bit          mr;
    logic [AW-1:0] dest;
  } instr_t;

  // Most recent instruction that entered EX is at the front; the one behind it is in MEM.
  instr_t inflight[$];
  int     m_stalls;
  int     m_busy_run;
  bit     m_timeout;

  hazard_scoreboard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
    .fwd_en(fwd_en), .branch_taken(branch_taken), .mem_busy(mem_busy), .hazard(hazard),
    .freeze_if(freeze_if), .bubble_ex(bubble_ex), .flush(flush), .freeze_all(freeze_all),
    .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic instr_t bubble_i();
    instr_t b;
    b.v = 0; b.wb = 0; b.mr = 0; b.dest = '0;
    return b;
  endfunction

  task automatic model_reset();
    inflight.delete();
    inflight.push_front(bubble_i());
    inflight.push_front(bubble_i());
    m_stalls   = 0;
    m_busy_run = 0;
    m_timeout  = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, advance the model at the edge.
  task automatic cyc(input bit r, input bit v, input int s1, input int s2, input bit two,
                     input bit wb, input bit mr, input int dst, input bit fwd,
                     input bit br, input bit busy);
    bit     dep;
    bit     e_hz, e_fl, e_fa;
    instr_t nw;
    rst = r; id_valid = v; id_src1 = AW'(s1); id_src2 = AW'(s2); id_two_src = two;
    id_wb_en = wb; id_mem_read = mr; id_dest = AW'(dst); fwd_en = fwd;
    branch_taken = br; mem_busy = busy;
    dep = 0;
    for (int age = 0; age < 2; age++) begin
      instr_t e;
      e = inflight[age];
      if (e.v && e.wb && (e.dest == AW'(s1) || (two && e.dest == AW'(s2)))) begin
        if (!fwd) dep = 1;
        else if (age == 0 && e.mr) dep = 1;
      end
    end
    e_fa = busy;
    e_fl = !busy && br;
    e_hz = !busy && !br && v && dep;
    @(negedge clk);
    chk("freeze_all", int'(freeze_all), int'(e_fa));
    chk("flush", int'(flush), int'(e_fl));
    chk("hazard", int'(hazard), int'(e_hz));
    chk("bubble_ex", int'(bubble_ex), int'(e_hz));
    chk("freeze_if", int'(freeze_if), int'(e_hz || e_fa));
    chk("stall_cycles", int'(stall_cycles), (m_stalls > CNT_SAT) ? CNT_SAT : m_stalls);
    chk("mem_timeout", int'(mem_timeout), int'(m_timeout));
    $display("cyc t=%0t rst=%0b v=%0b s1=%0d s2=%0d two=%0b dst=%0d fwd=%0b br=%0b busy=%0b -> hz=%0b fl=%0b fa=%0b st=%0d to=%0b",
             $time, r, v, s1, s2, two, dst, fwd, br, busy, hazard, flush, freeze_all,
             stall_cycles, mem_timeout);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (!busy) begin
        if (e_fl || e_hz) nw = bubble_i();
        else begin
          nw.v = v; nw.wb = wb; nw.mr = mr; nw.dest = AW'(dst);
        end
        inflight.push_front(nw);
        void'(inflight.pop_back());
      end
      if (e_hz || e_fa) m_stalls++;
      m_busy_run = busy ? m_busy_run + 1 : 0;
      if (m_busy_run >= MAXW) m_timeout = 1;
    end
    #1;
  endtask

  task automatic idle(input bit fwd);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, fwd, 0, 0);
  endtask

  initial begin
    model_reset();
    rst = 1; id_valid = 0; id_src1 = '0; id_src2 = '0; id_two_src = 0; id_wb_en = 0;
    id_mem_read = 0; id_dest = '0; fwd_en = 0; branch_taken = 0; mem_busy = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    // reset state
    idle(0);
    chk("reset_stall_cycles", int'(stall_cycles), 0);

    // 1: no forwarding, ADD R3 then SUB R?,R3 -> two stall cycles then issue
    cyc(0, 1, 1, 2, 1, 1, 0, 3, 0, 0, 0);
    cyc(0, 1, 3, 0, 0, 1, 0, 4, 0, 0, 0);
    cyc(0, 1, 3, 0, 0, 1, 0, 4, 0, 0, 0);
    cyc(0, 1, 3, 0, 0, 1, 0, 4, 0, 0, 0);
    chk("t1_stall_cycles", int'(stall_cycles), 2);
    idle(0); idle(0);

    // 2: forwarding, LDR R5 then ADD using src2=R5 -> single stall; with two_src=0 none
    cyc(0, 1, 0, 0, 0, 1, 1, 5, 1, 0, 0);
    cyc(0, 1, 1, 5, 1, 1, 0, 6, 1, 0, 0);
    cyc(0, 1, 1, 5, 1, 1, 0, 6, 1, 0, 0);
    idle(1); idle(1);
    cyc(0, 1, 0, 0, 0, 1, 1, 5, 1, 0, 0);
    cyc(0, 1, 1, 5, 0, 1, 0, 6, 1, 0, 0);
    idle(1); idle(1);

    // 3: raw and branch in the same cycle -> flush wins, EX becomes a bubble
    cyc(0, 1, 0, 0, 0, 1, 0, 7, 0, 0, 0);
    cyc(0, 1, 7, 0, 0, 1, 0, 8, 0, 1, 0);
    cyc(0, 1, 7, 0, 0, 1, 0, 8, 0, 0, 0);
    idle(0); idle(0);

    // 4: three busy cycles mask a taken branch, which flushes on the fourth
    cyc(0, 1, 0, 0, 0, 1, 0, 9, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 9, 0, 0, 1, 0, 10, 0, 1, 1);
    cyc(0, 1, 9, 0, 0, 1, 0, 10, 0, 1, 0);
    idle(0); idle(0);

    // 5: four busy cycles -> sticky timeout
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0);
    chk("t5_timeout_sticky", int'(mem_timeout), 1);
    idle(0);

    // 6: reset in the middle of a 2-cycle stall, then the same source issues cleanly
    cyc(0, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0);
    cyc(0, 1, 3, 0, 0, 1, 0, 4, 0, 0, 0);
    cyc(1, 1, 3, 0, 0, 1, 0, 4, 0, 0, 0);
    cyc(0, 1, 3, 0, 0, 1, 0, 4, 0, 0, 0);
    chk("t6_timeout_cleared", int'(mem_timeout), 0);
    idle(0);

    // stall counter saturation
    for (int i = 0; i < CNT_SAT + 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("sat_stall_cycles", int'(stall_cycles), CNT_SAT);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // random traffic on a small register set to provoke frequent dependencies
    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
